// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
// Prefetch stage between instruction memory port 1 and the CPU datapath.
// Issues sequential word reads, queues the returned words together with
// their PC in a small FIFO and presents the head entry to the CPU. A
// redirect flushes the FIFO, restarts fetch at a new PC and abandons any
// read still in flight.
module instr_fetch_buffer #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    output logic                 readM1,
    output logic [WORD_SIZE-1:0] address1,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic                 mem_ack1,
    input  logic                 cpu_pop,
    output logic                 cpu_valid,
    output logic [WORD_SIZE-1:0] cpu_inst,
    output logic [WORD_SIZE-1:0] cpu_pc,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic [PTR_W:0]       count
);

    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    // IDLE: nothing outstanding. REQ: live read whose data will be queued.
    // DISCARD: read still owed an ack by memory but its data is unwanted.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 readm1_nxt;
    logic [WORD_SIZE-1:0] addr_nxt;
    logic [WORD_SIZE-1:0] fetch_pc;
    logic [WORD_SIZE-1:0] fetch_pc_nxt;
    logic [WORD_SIZE-1:0] fetch_pc_inc;
    logic [CNT_W-1:0]     count_after;
    logic [CNT_W-1:0]     count_nxt;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr_nxt;
    logic [PTR_W-1:0]     rd_ptr_nxt;

    logic                 pop_ok;
    logic                 push;
    logic                 space;
    logic                 issue_ok;

    logic [WORD_SIZE-1:0] fifo_inst [DEPTH];
    logic [WORD_SIZE-1:0] fifo_pc   [DEPTH];

    // Head presentation; outputs are forced to zero while the FIFO is empty
    // so the CPU never sees stale storage contents.
    assign cpu_valid = (count != '0);
    assign cpu_inst  = cpu_valid ? fifo_inst[rd_ptr] : '0;
    assign cpu_pc    = cpu_valid ? fifo_pc[rd_ptr]   : '0;

    // A pop is only honoured against a real entry; a push happens only for
    // a live (not abandoned) request, and never on a redirect edge.
    assign pop_ok       = cpu_pop && cpu_valid;
    assign push         = (state == S_REQ) && mem_ack1 && !redirect;
    assign count_after  = count + CNT_W'(push) - CNT_W'(pop_ok);
    // A new read is only issued when a slot is already reserved for its data,
    // which is what makes FIFO overflow impossible.
    assign space        = (count_after < FULL);
    assign issue_ok     = space && !halt;
    assign fetch_pc_inc = fetch_pc + WORD_SIZE'(1);

    // Next-state and next-value logic for the fetch controller and FIFO control.
    always_comb begin
        state_nxt    = state;
        readm1_nxt   = readM1;
        addr_nxt     = address1;
        fetch_pc_nxt = fetch_pc;
        count_nxt    = count_after;
        wr_ptr_nxt   = wr_ptr + PTR_W'(push);
        rd_ptr_nxt   = rd_ptr + PTR_W'(pop_ok);

        if (redirect) begin
            // Flush wins over any push/pop on this edge.
            count_nxt    = '0;
            wr_ptr_nxt   = '0;
            rd_ptr_nxt   = '0;
            fetch_pc_nxt = redirect_pc;
            unique case (state)
                S_IDLE: begin
                    state_nxt = S_IDLE;
                end
                S_REQ, S_DISCARD: begin
                    if (mem_ack1) begin
                        // Outstanding read completes now; its data is dropped.
                        state_nxt  = S_IDLE;
                        readm1_nxt = 1'b0;
                    end else begin
                        // Memory still owes an ack: keep the request stable.
                        state_nxt = S_DISCARD;
                    end
                end
                default: begin
                    state_nxt  = S_IDLE;
                    readm1_nxt = 1'b0;
                end
            endcase
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (issue_ok) begin
                        state_nxt  = S_REQ;
                        readm1_nxt = 1'b1;
                        addr_nxt   = fetch_pc;
                    end
                end
                S_REQ: begin
                    if (mem_ack1) begin
                        fetch_pc_nxt = fetch_pc_inc;
                        if (issue_ok) begin
                            // Back-to-back issue of the next sequential word.
                            addr_nxt = fetch_pc_inc;
                        end else begin
                            state_nxt  = S_IDLE;
                            readm1_nxt = 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    if (mem_ack1) begin
                        state_nxt  = S_IDLE;
                        readm1_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt  = S_IDLE;
                    readm1_nxt = 1'b0;
                end
            endcase
        end
    end

    // Fetch controller state register.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory request, fetch PC, occupancy and FIFO pointer registers.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            readM1   <= 1'b0;
            address1 <= '0;
            fetch_pc <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            readM1   <= readm1_nxt;
            address1 <= addr_nxt;
            fetch_pc <= fetch_pc_nxt;
            count    <= count_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
        end
    end

    // FIFO storage; the entry's PC is the fetch PC of the request being acked.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= data1;
            fifo_pc[wr_ptr]   <= fetch_pc;
        end
    end

    // An ack for a live request while the FIFO is full breaks the slot
    // reservation contract with memory.
    a_no_overflow : assert property (@(posedge Clk) disable iff (!Reset_N)
        (state == S_REQ && mem_ack1) |-> (count != FULL));

    // Occupancy never exceeds the FIFO depth.
    a_count_range : assert property (@(posedge Clk) disable iff (!Reset_N)
        count <= FULL);

    // The read strobe tracks exactly the states that own a request.
    a_readm1_state : assert property (@(posedge Clk) disable iff (!Reset_N)
        readM1 == (state != S_IDLE));

    // The read address is held until memory acknowledges it.
    a_addr_stable : assert property (@(posedge Clk) disable iff (!Reset_N)
        (readM1 && !mem_ack1) |=> $stable(address1));

endmodule
